// File: rtl/fpga_cfg_chain_loader.sv
// Loads a serial configuration-flip-flop chain from a word stream, then releases fabric reset.
// Optional CRC-8 check of the shifted bits is enabled with `define FPGA_CFG_CRC_EN.
//
// state   | meaning
// IDLE    | waiting for cfg_start, fabric held in reset
// LOAD    | s_ready high, waiting for the next bitstream word
// SHIFT   | one bit per cycle into ccff_head with prog_en high
// CRC     | (FPGA_CFG_CRC_EN only) accepts the expected-CRC word
// RELEASE | chain full, fabric_reset held for RELEASE_CYCLES cycles
// DONE    | fabric running, done high
module fpga_cfg_chain_loader #(
    parameter int CHAIN_LEN      = 1024,
    parameter int WORD_W         = 8,
    parameter int RELEASE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              prog_en,
    output logic              fabric_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int WC_W  = $clog2(WORD_W + 1);
    localparam int RC_W  = $clog2(RELEASE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

`ifdef FPGA_CFG_CRC_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_CRC, S_RELEASE, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_RELEASE, S_DONE} state_t;
`endif

    state_t            state, state_next;
    logic [WORD_W-1:0] sreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WC_W-1:0]   wrem;
    logic [RC_W-1:0]   rel_cnt;
    logic              accept;
    logic              start_ok;
    logic              unused_tail;

    assign unused_tail = ccff_tail;
    assign accept      = s_valid && s_ready;
    assign start_ok    = cfg_start && (state == S_IDLE || state == S_DONE);

`ifdef FPGA_CFG_CRC_EN
    logic [7:0]        crc;
    logic [7:0]        crc_word;
    logic [WORD_W+7:0] crc_ext;
    logic              crc_match;
    logic              error_q;

    assign crc_ext   = {8'h00, s_data};
    assign crc_word  = crc_ext[7:0];
    assign crc_match = (crc_word == crc);
    assign error     = error_q;

    // MSB-first CRC-8, poly 0x07, updated with each bit as it leaves on ccff_head
    always_ff @(posedge clk) begin
        if (reset) begin
            crc     <= 8'h00;
            error_q <= 1'b0;
        end else if (start_ok) begin
            crc     <= 8'h00;
            error_q <= 1'b0;
        end else if (state == S_SHIFT) begin
            crc <= {crc[6:0], 1'b0} ^ ({8{crc[7] ^ ccff_head}} & 8'h07);
        end else if (state == S_CRC && accept && !crc_match) begin
            error_q <= 1'b1;
        end
    end
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: if (cfg_start) state_next = S_LOAD;
            S_LOAD:         if (accept) state_next = S_SHIFT;
            S_SHIFT: begin
                if (bit_cnt == LAST_BIT) begin
`ifdef FPGA_CFG_CRC_EN
                    state_next = S_CRC;
`else
                    state_next = S_RELEASE;
`endif
                end else if (wrem == '0) begin
                    state_next = S_LOAD;
                end
            end
`ifdef FPGA_CFG_CRC_EN
            S_CRC:          if (accept) state_next = crc_match ? S_RELEASE : S_IDLE;
`endif
            S_RELEASE:      if (rel_cnt == '0) state_next = S_DONE;
            default:        state_next = S_IDLE;
        endcase
    end

    always_comb begin
        s_ready      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        fabric_reset = 1'b1;
        case (state)
            S_LOAD:    begin s_ready = 1'b1; busy = 1'b1; end
            S_SHIFT:   busy = 1'b1;
`ifdef FPGA_CFG_CRC_EN
            S_CRC:     begin s_ready = 1'b1; busy = 1'b1; end
`endif
            S_RELEASE: busy = 1'b1;
            S_DONE:    begin done = 1'b1; fabric_reset = 1'b0; end
            default:   ;
        endcase
    end

    // ccff_head/prog_en are registered from the next state so a word accepted
    // in cycle N presents its first bit in cycle N+1
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg      <= '0;
            bit_cnt   <= '0;
            wrem      <= '0;
            rel_cnt   <= '0;
            ccff_head <= 1'b0;
            prog_en   <= 1'b0;
        end else begin
            prog_en <= (state_next == S_SHIFT);
            if (start_ok) bit_cnt <= '0;
            if (state == S_LOAD && accept) begin
                ccff_head <= s_data[0];
                sreg      <= s_data >> 1;
                wrem      <= WC_W'(WORD_W - 1);
            end
            if (state == S_SHIFT) begin
                bit_cnt <= bit_cnt + 1'b1;
                if (state_next == S_SHIFT) begin
                    ccff_head <= sreg[0];
                    sreg      <= sreg >> 1;
                    wrem      <= wrem - 1'b1;
                end
            end
            if (state_next == S_RELEASE && state != S_RELEASE)
                rel_cnt <= RC_W'(RELEASE_CYCLES - 1);
            else if (state == S_RELEASE && rel_cnt != '0)
                rel_cnt <= rel_cnt - 1'b1;
        end
    end
endmodule
